press_count_display: RTL and testbench



---
 rtl/seg_display_pkg.sv | 25 ++
 rtl/bcd_to_seg7.sv | 26 ++
 rtl/press_count_display.sv | 110 +++++++++++
 tb/tb_press_count_display.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_display_pkg.sv
// rtl/seg_display_pkg.sv - shared types and constants for the press counter display
package seg_display_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [3:0] bcd_t;

    // Active-low cathode patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    localparam bcd_t BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - combinational BCD digit to active-low seven-segment decoder
module bcd_to_seg7
    import seg_display_pkg::*;
(
    input  bcd_t       bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/press_count_display.sv
// rtl/press_count_display.sv - counts debounced button presses in BCD and scans them onto the 7-seg display
module press_count_display
    import seg_display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       D_IN,
    input  logic       CLR,
    output logic [7:0] AN,
    output logic [6:0] SEG,
    output logic       DP
);

    localparam int             RW       = $clog2(REFRESH_DIV);
    localparam logic [RW-1:0]  REF_LAST = RW'(REFRESH_DIV - 1);

    logic                        prev_q;
    logic                        press;
    bcd_t [NUM_DIGITS-1:0]       cnt_q, cnt_d;
    logic [RW-1:0]               refresh_q, refresh_d;
    logic [1:0]                  scan_q, scan_d;
    logic [7:0]                  an_q, an_d;
    logic [6:0]                  seg_q, seg_d;
    logic [NUM_DIGITS-1:0]       blank;
    logic                        upper_zero;
    logic                        carry;
    logic                        slot_wrap;
    bcd_t                        sel_digit;
    logic [6:0]                  sel_seg;

    // prev resets high so a button held through reset release is not a press
    assign press = D_IN & ~prev_q;

    always_comb begin
        cnt_d = cnt_q;
        carry = press;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (cnt_q[i] >= BCD_MAX) begin
                    cnt_d[i] = 4'd0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 4'd1;
                    carry    = 1'b0;
                end
            end
        end
        if (CLR) begin
            cnt_d = '0;
        end
    end

    assign slot_wrap = (refresh_q == REF_LAST);

    always_comb begin
        refresh_d = slot_wrap ? '0 : refresh_q + 1'b1;
        scan_d    = slot_wrap ? scan_q + 2'd1 : scan_q;
    end

    // A digit is blanked only when it and every more significant digit are zero
    always_comb begin
        blank      = '0;
        upper_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            upper_zero = upper_zero & (cnt_q[i] == 4'd0);
            blank[i]   = BLANK_LZ & upper_zero;
        end
    end

    assign sel_digit = cnt_q[scan_q];

    bcd_to_seg7 u_dec (
        .bcd_i (sel_digit),
        .seg_o (sel_seg)
    );

    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        if (!blank[scan_q]) begin
            an_d  = AN_OFF & ~(8'h01 << scan_q);
            seg_d = sel_seg;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prev_q    <= 1'b1;
            cnt_q     <= '0;
            refresh_q <= '0;
            scan_q    <= 2'd0;
            an_q      <= AN_OFF;
            seg_q     <= SEG_OFF;
        end else begin
            prev_q    <= D_IN;
            cnt_q     <= cnt_d;
            refresh_q <= refresh_d;
            scan_q    <= scan_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign AN  = an_q;
    assign SEG = seg_q;
    assign DP  = 1'b1;

endmodule

// File: tb/tb_press_count_display.sv
// tb/tb_press_count_display.sv - directed self-checking bench for press_count_display
module tb_press_count_display;

    logic       CLK = 1'b0;
    logic       RST;
    logic       D_IN;
    logic       CLR;
    logic [7:0] an_lz, an_nb;
    logic [6:0] seg_lz, seg_nb;
    logic       dp_lz, dp_nb;

    logic [6:0] seg_tab [10];
    logic [7:0] an_seq  [4];

    int n_total = 0;
    int n_bad   = 0;

    always #5 CLK = ~CLK;

    press_count_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) u_dut_lz (
        .CLK (CLK), .RST (RST), .D_IN (D_IN), .CLR (CLR),
        .AN  (an_lz), .SEG (seg_lz), .DP (dp_lz)
    );

    press_count_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) u_dut_nb (
        .CLK (CLK), .RST (RST), .D_IN (D_IN), .CLR (CLR),
        .AN  (an_nb), .SEG (seg_nb), .DP (dp_nb)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic press_n(input int n, input int hi);
        repeat (n) begin
            @(negedge CLK);
            D_IN = 1'b1;
            repeat (hi) @(negedge CLK);
            D_IN = 1'b0;
        end
    endtask

    // Samples one whole frame from both instances and compares to the count n
    task automatic check_frame(input string tag, input int n);
        int d [4];
        int blanked;
        int ff_cycles;
        int bad_cycles;
        logic [3:0][6:0] seen;
        logic [3:0][6:0] exp_nb;
        logic [6:0] lz0;
        for (int i = 0; i < 4; i++) d[i] = (n / (10 ** i)) % 10;
        blanked = (n < 10) ? 3 : (n < 100) ? 2 : (n < 1000) ? 1 : 0;
        exp_nb  = {seg_tab[d[3]], seg_tab[d[2]], seg_tab[d[1]], seg_tab[d[0]]};
        seen       = {4{7'h7F}};
        lz0        = 7'h7F;
        ff_cycles  = 0;
        bad_cycles = 0;
        repeat (3) @(negedge CLK);
        for (int c = 0; c < 16; c++) begin
            @(negedge CLK);
            case (an_nb)
                8'hFE: seen[0] = seg_nb;
                8'hFD: seen[1] = seg_nb;
                8'hFB: seen[2] = seg_nb;
                8'hF7: seen[3] = seg_nb;
                default: bad_cycles++;
            endcase
            if (an_lz == 8'hFF) begin
                ff_cycles++;
                if (seg_lz !== 7'h7F) bad_cycles++;
            end else if (an_lz == 8'hFE) begin
                lz0 = seg_lz;
            end else if (an_lz != 8'hFD && an_lz != 8'hFB && an_lz != 8'hF7) begin
                bad_cycles++;
            end
            if (dp_lz !== 1'b1 || dp_nb !== 1'b1) bad_cycles++;
        end
        chk({tag, "_digits"}, {4'b0, seen}, {4'b0, exp_nb});
        chk({tag, "_blank_cycles"}, ff_cycles, 4 * blanked);
        chk({tag, "_lz_d0"}, lz0, seg_tab[d[0]]);
        chk({tag, "_bad_cycles"}, bad_cycles, 0);
    endtask

    task automatic check_cadence();
        logic [7:0] start_an;
        logic [7:0] cur;
        int k;
        int len;
        int waited;
        start_an = an_nb;
        waited   = 0;
        while (an_nb == start_an && waited < 10) begin
            @(negedge CLK);
            waited++;
        end
        chk("cad_start", (an_nb != start_an), 1);
        k = -1;
        for (int i = 0; i < 4; i++) if (an_seq[i] == an_nb) k = i;
        chk("cad_known", (k >= 0), 1);
        if (k < 0) k = 0;
        for (int r = 0; r < 4; r++) begin
            cur = an_nb;
            len = 0;
            while (an_nb == cur && len < 10) begin
                @(negedge CLK);
                len++;
            end
            chk($sformatf("cad_an%0d", r), cur, an_seq[(k + r) % 4]);
            chk($sformatf("cad_len%0d", r), len, 4);
        end
    endtask

    initial begin
        int viol;
        int k;
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        an_seq  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7};
        RST  = 1'b1;
        D_IN = 1'b0;
        CLR  = 1'b0;

        // Reset held with D_IN toggling
        repeat (2) @(negedge CLK);
        chk("rst_an", an_lz, 8'hFF);
        chk("rst_seg", seg_lz, 7'h7F);
        chk("rst_dp", dp_lz, 1'b1);
        viol = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            D_IN = ~D_IN;
            if (an_lz !== 8'hFF || seg_lz !== 7'h7F || an_nb !== 8'hFF || seg_nb !== 7'h7F) viol++;
        end
        chk("rst_hold", viol, 0);
        @(negedge CLK);
        D_IN = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check_frame("rel_held", 0);
        @(negedge CLK);
        D_IN = 1'b0;

        // Long presses and leading-zero blanking
        press_n(3, 10);
        check_frame("three", 3);

        // Back-to-back presses, then CLR against press
        press_n(39, 1);
        check_frame("c42", 42);
        @(negedge CLK);
        D_IN = 1'b1;
        CLR  = 1'b1;
        @(negedge CLK);
        D_IN = 1'b0;
        CLR  = 1'b0;
        check_frame("clr_press", 0);
        @(negedge CLK);
        CLR = 1'b1;
        @(negedge CLK);
        CLR  = 1'b0;
        D_IN = 1'b1;
        @(negedge CLK);
        D_IN = 1'b0;
        check_frame("after_clr", 1);
        CLR = 1'b1;
        press_n(3, 1);
        check_frame("clr_held", 0);
        @(negedge CLK);
        CLR = 1'b0;

        // Scan cadence at 1234
        press_n(1234, 1);
        check_frame("c1234", 1234);
        check_cadence();

        // Carry chain and full wrap
        @(negedge CLK);
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        press_n(9, 1);    check_frame("c9", 9);
        press_n(1, 1);    check_frame("c10", 10);
        press_n(89, 1);   check_frame("c99", 99);
        press_n(1, 1);    check_frame("c100", 100);
        press_n(899, 1);  check_frame("c999", 999);
        press_n(1, 1);    check_frame("c1000", 1000);
        press_n(8999, 1); check_frame("c9999", 9999);
        press_n(1, 1);    check_frame("wrap", 0);

        // Reset during the digit-2 slot
        press_n(5, 1);
        k = 0;
        while (an_nb != 8'hFB && k < 40) begin
            @(negedge CLK);
            k++;
        end
        chk("mid_found_d2", an_nb, 8'hFB);
        #2;
        RST = 1'b1;
        #1;
        chk("mid_an_nb", an_nb, 8'hFF);
        chk("mid_seg_nb", seg_nb, 7'h7F);
        chk("mid_an_lz", an_lz, 8'hFF);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        k = 0;
        while (an_nb == 8'hFF && k < 10) begin
            @(negedge CLK);
            k++;
        end
        chk("mid_first_an", an_nb, 8'hFE);
        chk("mid_first_lat", k, 1);
        check_frame("mid_after", 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
